pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter LINE_PIXELS, default 640, pixels per line; SHALL be a multiple of 4, so each line is LINE_PIXELS*3/4 words (480 words at default).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset: synchronous and active-high.
REQ-004 in_pixel  input  24  RGB pixel, byte 0 = bits 7:0.
REQ-005 in_valid  input  1  in_pixel is valid.
REQ-006 in_ready  output  1  block accepts the pixel this cycle.
REQ-007 in_sof  input  1  first pixel of frame.
REQ-008 in_eol  input  1  last pixel of line.
REQ-009 out_stream_tdata  output  32  packed word.
REQ-010 out_stream_tkeep  output  4  constant 4'hF.
REQ-011 out_stream_tvalid  output  1  word is valid.
REQ-012 out_stream_tready  input  1  downstream accepts the word.
REQ-013 out_stream_tuser  output  1  SOF, set on the first word of a frame.
REQ-014 out_stream_tlast  output  1  EOL, set on the last word of a line.
REQ-015 err_flags  output  3  sticky flags: {len_err, eol_err, sof_err}.

Function
REQ-016 Handshake: an input transfer SHALL occur on in_valid && in_ready; an output transfer on tvalid && tready.
REQ-017 Ready rule: in_ready SHALL equal !out_stream_tvalid || out_stream_tready, combinationally, with no dependence on in_valid.
REQ-018 Phase counter: a 2-bit counter (0..3) SHALL advance by 1 per accepted pixel and wrap from 3 to 0; a residual register holds up to 3 leftover bytes r.
REQ-019 Packing per accepted pixel p (little-endian byte stream):
- phase0: store r=p; no word out.
- phase1: emit {p[7:0], r[23:0]}; store p[23:8].
- phase2: emit {p[15:0], r[15:0]}; store p[23:16].
- phase3: emit {p[23:0], r[7:0]}; residual empty.
REQ-020 Emitted words SHALL be registered: tvalid rises the cycle after the accepting edge, giving 1-cycle latency.
REQ-021 Output stability: while tvalid && !tready, tdata, tuser and tlast SHALL hold.
REQ-022 tuser: in_sof latched at phase0 SHALL set tuser on the phase1 word only.
REQ-023 tlast: an in_eol pixel at phase3 SHALL set tlast on that pixel's word.
REQ-024 Early EOL: in_eol at phase != 3 SHALL emit that phase's word with tlast=1.
- At phase0 the word is {8'h00, p}.
- The remaining residual is discarded, phase returns to 0 and eol_err is set.
REQ-025 Late SOF: in_sof at phase != 0 SHALL discard the residual and treat the pixel as phase0; sof_err is set.
REQ-026 Line counter: a pixel counter SHALL count 0..LINE_PIXELS-1 and clear on in_eol or in_sof.
- Set len_err if in_eol arrives at count != LINE_PIXELS-1.
- Set len_err if the count reaches LINE_PIXELS-1 without in_eol; the counter then wraps to 0.
REQ-027 Simultaneous in_sof and in_eol on one pixel SHALL apply both rules: the word carries tuser and tlast, and the phase0 case uses padding.
REQ-028 Error flags SHALL clear only on rst.

Reset
REQ-029 On rst, all of these SHALL be 0: tvalid, tuser, tlast, tdata, phase, residual, pixel counter and err_flags.
REQ-030 Reset mid-line SHALL drop any held word and residual, and SHALL NOT produce a partial word afterwards; in_ready is 1 in the first cycle after reset.

Structure
REQ-031 Package pixgen_pkg SHALL hold:
- BYTES_PER_PIXEL=3, WORD_BYTES=4;
- the phase_t typedef (2-bit);
- the err index constants.
REQ-032 No sub-module SHALL be used; the single output register stage is inline.

Verification
REQ-033 Pixels 0x112233, 0x445566, 0x778899, 0xAABBCC, sof on the first, tready=1 -> words 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77; tlast=0 on all.
REQ-034 Full 640-pixel line with eol on the last pixel -> exactly 480 words, tlast only on word 479, err_flags=0.
REQ-035 Pseudo-random tready (50%) over 2 frames of 640x480 -> no lost or duplicated words, data held while stalled, one tuser per frame, 480 tlast per frame.
REQ-036 eol on pixel index 5 (phase1) -> that word has tlast=1; eol_err=1 and len_err=1; the next pixel restarts at phase0.
REQ-037 rst asserted after 2 pixels of a line -> the next cycle has tvalid=0 and err_flags=0, and the following 4 pixels produce the REQ-033 words.

Source files
------------

// File: rtl/pixgen_pkg.sv
// Shared types and constants for the RGB-to-32-bit pixel packer.
// Byte counts, phase encoding and error-flag bit positions.
package pixgen_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int WORD_BYTES      = 4;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  localparam int ERR_SOF = 0;
  localparam int ERR_EOL = 1;
  localparam int ERR_LEN = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs a 24-bit RGB pixel stream into little-endian 32-bit words,
// four pixels to three words, with SOF/EOL framing and sticky errors.
module pixel_packer
  import pixgen_pkg::*;
#(
  parameter int LINE_PIXELS = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        out_stream_tuser,
  output logic        out_stream_tlast,
  output logic [2:0]  err_flags
);

  localparam int CW =
    (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(LINE_PIXELS - 1);

  phase_t        phase_q, phase_d, ph;
  logic [23:0]   res_q, res_d;
  logic          sofp_q, sofp_d;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [2:0]    err_q, err_d;
  word_t         word_q, word_d, wnew;
  logic          vld_q, vld_d;
  logic          accept, emit;

  assign in_ready = !vld_q || out_stream_tready;
  assign accept   = in_valid && in_ready;

  // A late SOF restarts packing as if the pixel were at phase 0.
  assign ph  = in_sof ? PH0 : phase_q;
  assign idx = in_sof ? '0 : cnt_q;

  always_comb begin
    phase_d = phase_q;
    res_d   = res_q;
    sofp_d  = sofp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    word_d  = word_q;
    vld_d   = vld_q && !out_stream_tready;
    emit    = 1'b0;
    wnew    = '0;
    if (accept) begin
      wnew.last = in_eol;
      emit      = 1'b1;
      if (in_sof && phase_q != PH0) begin
        err_d[ERR_SOF] = 1'b1;
      end
      unique case (ph)
        PH0: begin
          wnew.data = {8'h00, in_pixel};
          wnew.user = in_sof;
          emit      = in_eol;
          res_d     = in_pixel;
          sofp_d    = in_sof;
        end
        PH1: begin
          wnew.data = {in_pixel[7:0], res_q};
          wnew.user = sofp_q;
          res_d     = {8'h00, in_pixel[23:8]};
          sofp_d    = 1'b0;
        end
        PH2: begin
          wnew.data = {in_pixel[15:0], res_q[15:0]};
          res_d     = {16'h0000, in_pixel[23:16]};
        end
        PH3: begin
          wnew.data = {in_pixel, res_q[7:0]};
          res_d     = '0;
        end
      endcase
      if (in_eol) begin
        phase_d = PH0;
        res_d   = '0;
        sofp_d  = 1'b0;
        if (ph != PH3) begin
          err_d[ERR_EOL] = 1'b1;
        end
      end else begin
        phase_d = phase_t'(2'(ph) + 2'd1);
      end
      if (in_eol) begin
        if (idx != CNT_LAST) begin
          err_d[ERR_LEN] = 1'b1;
        end
        cnt_d = '0;
      end else if (idx == CNT_LAST) begin
        err_d[ERR_LEN] = 1'b1;
        cnt_d          = '0;
      end else begin
        cnt_d = idx + CW'(1);
      end
      if (emit) begin
        word_d = wnew;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH0;
      res_q   <= '0;
      sofp_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      sofp_q  <= sofp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

  assign out_stream_tdata  = word_q.data;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tvalid = vld_q;
  assign out_stream_tuser  = word_q.user;
  assign out_stream_tlast  = word_q.last;
  assign err_flags         = err_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: directed vectors plus a
// byte-stream model for full lines under random backpressure.
module tb_pixel_packer;
  import pixgen_pkg::*;

  localparam int LP = 640;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic        in_eol;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [2:0]  err_flags;

  always #5 clk = ~clk;

  pixel_packer #(.LINE_PIXELS(LP)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_pixel         (in_pixel),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_sof           (in_sof),
    .in_eol           (in_eol),
    .out_stream_tdata (tdata),
    .out_stream_tkeep (tkeep),
    .out_stream_tvalid(tvalid),
    .out_stream_tready(tready),
    .out_stream_tuser (tuser),
    .out_stream_tlast (tlast),
    .err_flags        (err_flags)
  );

  word_t      exp_q[$];
  logic [7:0] mq[$];
  logic       m_sofp = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int words_seen = 0;
  int last_seen = 0;
  int user_seen = 0;
  bit rnd_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d,
                          input logic u,
                          input logic l);
    word_t w;
    w.data = d;
    w.user = u;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Byte-stream reference: 3 bytes in per pixel, 4 bytes out per word.
  task automatic model_pixel(input logic [23:0] p,
                             input logic s,
                             input logic e);
    bit emitted;
    logic [31:0] w;
    emitted = 1'b0;
    w = '0;
    if (s) begin
      mq.delete();
      m_sofp = 1'b1;
    end
    mq.push_back(p[7:0]);
    mq.push_back(p[15:8]);
    mq.push_back(p[23:16]);
    if (mq.size() >= 4 || e) begin
      while (mq.size() < 4) mq.push_back(8'h00);
      for (int k = 0; k < 4; k++) w[8*k +: 8] = mq.pop_front();
      emitted = 1'b1;
    end
    if (e) mq.delete();
    if (emitted) begin
      push_exp(w, m_sofp, e);
      m_sofp = 1'b0;
    end
  endtask

  task automatic send(input logic [23:0] p,
                      input logic s,
                      input logic e,
                      input bit mdl);
    int t;
    in_pixel = p;
    in_sof   = s;
    in_eol   = e;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) break;
    end
    if (t > 200) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
    end else if (mdl) begin
      model_pixel(p, s, e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pop on each output transfer, check hold while stalled.
  initial begin
    bit    stall;
    word_t held, got, e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      got.data = tdata;
      got.user = tuser;
      got.last = tlast;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_word", 64'(got), 64'(held));
          chk("hold_valid", 64'(tvalid), 64'd1);
        end
        if (tvalid && tready) begin
          words_seen++;
          if (tlast) last_seen++;
          if (tuser) user_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(got), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'(got), 64'(e));
          end
        end
        stall = tvalid && !tready;
        held  = got;
      end
    end
  end

  initial begin
    int w0, l0, u0;
    rst      = 1'b1;
    tready   = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("tkeep", 64'(tkeep), 64'hF);
    @(posedge clk);
    #1;

    // Basic four-pixel group
    push_exp(32'h66112233, 1'b1, 1'b0);
    push_exp(32'h88994455, 1'b0, 1'b0);
    push_exp(32'hAABBCC77, 1'b0, 1'b0);
    send(24'h112233, 1'b1, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
    drain();
    chk("err_basic", 64'(err_flags), 64'd0);

    // Early EOL on pixel index 5 (phase 1)
    push_exp(32'h66112233, 1'b1, 1'b0);
    push_exp(32'h88994455, 1'b0, 1'b0);
    push_exp(32'hAABBCC77, 1'b0, 1'b0);
    push_exp(32'h06010203, 1'b0, 1'b1);
    send(24'h112233, 1'b1, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
    send(24'h010203, 1'b0, 1'b0, 1'b0);
    send(24'h040506, 1'b0, 1'b1, 1'b0);
    drain();
    chk("err_early_eol", 64'(err_flags), 64'b110);
    push_exp(32'h66112233, 1'b0, 1'b0);
    push_exp(32'h88994455, 1'b0, 1'b0);
    push_exp(32'hAABBCC77, 1'b0, 1'b0);
    send(24'h112233, 1'b0, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
    drain();
    chk("err_sticky", 64'(err_flags), 64'b110);

    // Reset mid-line with a held word
    tready = 1'b0;
    send(24'h112233, 1'b1, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("held_before_rst", 64'({tvalid, tdata}),
        {31'd0, 1'b1, 32'h66112233});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_err", 64'(err_flags), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    tready = 1'b1;
    push_exp(32'h66112233, 1'b1, 1'b0);
    push_exp(32'h88994455, 1'b0, 1'b0);
    push_exp(32'hAABBCC77, 1'b0, 1'b0);
    send(24'h112233, 1'b1, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0, 1'b0);
    drain();

    // Full line, no backpressure: eol on the last pixel
    w0 = words_seen;
    l0 = last_seen;
    for (int i = 0; i < LP; i++) begin
      send({8'(i), 8'(i * 7), 8'(i) ^ 8'h5A},
           i == 0, i == LP - 1, 1'b1);
    end
    drain();
    chk("line_words", 64'(words_seen - w0), 64'd480);
    chk("line_tlast", 64'(last_seen - l0), 64'd1);
    chk("line_err", 64'(err_flags), 64'd0);

    // Two frames of two lines each under random tready
    w0 = words_seen;
    l0 = last_seen;
    u0 = user_seen;
    rnd_on = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int ln = 0; ln < 2; ln++) begin
        for (int i = 0; i < LP; i++) begin
          send({8'(f * 31 + ln), 8'(i >> 2), 8'(i * 13)},
               ln == 0 && i == 0, i == LP - 1, 1'b1);
        end
      end
    end
    rnd_on = 1'b0;
    #1;
    tready = 1'b1;
    drain();
    chk("rnd_words", 64'(words_seen - w0), 64'd1920);
    chk("rnd_tlast", 64'(last_seen - l0), 64'd4);
    chk("rnd_tuser", 64'(user_seen - u0), 64'd2);
    chk("rnd_err", 64'(err_flags), 64'd0);

    // Late SOF, then SOF and EOL on the same pixel
    push_exp(32'h66112233, 1'b1, 1'b0);
    push_exp(32'hCC778899, 1'b1, 1'b1);
    push_exp(32'h00123456, 1'b1, 1'b1);
    send(24'h112233, 1'b1, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b0, 1'b0);
    send(24'h778899, 1'b1, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b1, 1'b0);
    send(24'h123456, 1'b1, 1'b1, 1'b0);
    drain();
    chk("err_all", 64'(err_flags), 64'b111);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
